// File: rtl/count_mod_n.sv
// count_mod_n: modulo-N up/down counter with count enable and terminal-count flag
//
// Ports:
//   clk      in   1      rising-edge clock
//   rstn     in   1      asynchronous active-high reset, forces count to 0
//   enable   in   1      count enable; 0 holds the current value
//   up_down  in   1      1 counts up, 0 counts down
//   count    out  width  registered count, always within 0..modulo-1
//   tc       out  1      high in the cycle whose next edge wraps the counter
module count_mod_n #(
    parameter int modulo = 10,
    localparam int width = $clog2(modulo)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             up_down,
    output logic [width-1:0] count,
    output logic             tc
);
    localparam logic [width-1:0] last = width'(modulo - 1);

    logic [width-1:0] count_nxt;

    // Out-of-range values cannot occur in normal operation; if one ever
    // appears it is sent back to 0 on the next enabled edge.
    always_comb begin
        count_nxt = count;
        if (enable)
            count_nxt = (count > last)  ? '0 :
                        up_down         ? ((count == last) ? '0 : count + 1'b1) :
                                          ((count == '0) ? last : count - 1'b1);
    end

    always_ff @(posedge clk or posedge rstn)
        if (rstn)
            count <= '0;
        else
            count <= count_nxt;

    assign tc = enable & (up_down ? (count == last) : (count == '0));
endmodule

// File: tb/tb_count_mod_n.sv
// tb_count_mod_n: scoreboard bench for count_mod_n against an integer modulo model
module tb_count_mod_n;
    localparam int n = 10;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       enable = 1'b0;
    logic       up_down = 1'b1;
    logic [3:0] count;
    logic       tc;

    typedef struct {
        int   c;
        logic t;
        string name;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   m = 0;
    int   checks = 0;
    int   errors = 0;

    count_mod_n #(.modulo(n)) dut (
        .clk(clk),
        .rstn(rstn),
        .enable(enable),
        .up_down(up_down),
        .count(count),
        .tc(tc)
    );

    always #10 clk = ~clk;

    function automatic logic model_tc(input int v, input logic e, input logic u);
        return e && ((u && v == n - 1) || (!u && v == 0));
    endfunction

    task automatic push(input string name);
        exp_t e;
        e.c = m;
        e.t = model_tc(m, enable, up_down);
        e.name = name;
        q.push_back(e);
        -> sample_ev;
    endtask

    task automatic step(input logic e, input logic u, input logic r, input string name);
        @(negedge clk);
        enable = e;
        up_down = u;
        rstn = r;
        if (r) m = 0;
        #2;
        push(name);
        @(posedge clk);
        #1;
        if (!r && e) m = u ? (m + 1) % n : (m + n - 1) % n;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (int'(count) != e.c) begin
                    errors++;
                    $display("FAIL %s count: got %0d expected %0d at %0t", e.name, count, e.c, $time);
                end
                checks++;
                if (tc !== e.t) begin
                    errors++;
                    $display("FAIL %s tc: got %b expected %b at %0t", e.name, tc, e.t, $time);
                end
            end
        end
    end

    initial begin
        repeat (2) step(0, 1, 1, "reset_hold");
        repeat (2) step(0, 1, 0, "release_hold");
        repeat (14) step(1, 1, 0, "count_up");
        repeat (5) step(1, 0, 0, "count_down");
        repeat (3) step(0, 1, 0, "frozen_up_at_9");
        repeat (9) step(1, 0, 0, "down_to_0");
        repeat (3) step(0, 0, 0, "frozen_down_at_0");
        repeat (7) step(1, 1, 0, "up_to_7");
        #4;
        rstn = 1'b1;
        m = 0;
        #1;
        push("async_reset_mid");
        repeat (2) step(1, 1, 1, "reset_overrides_enable");
        repeat (3) step(1, 1, 0, "count_after_reset");
        repeat (300)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 19) == 0), "random");
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
